// File: rtl/sema_arb_pkg.sv
// Shared types and bus-address helper for the semaphore arbiter.
package sema_arb_pkg;

    typedef enum logic [1:0] {
        OP_TAKE = 2'b00,
        OP_GIVE = 2'b01,
        OP_PEEK = 2'b10,
        OP_SET  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_PEEK,
        S_PGAP,
        S_DEC,
        S_RESP
    } state_t;

    localparam int unsigned ADR_W = 13;

    // abs=1 addresses the raw count; abs=0 applies amt as a relative inc (write) / dec (read).
    function automatic logic [ADR_W-1:0] mk_adr(input logic abs_mode,
                                                input logic [7:0] sem,
                                                input logic [3:0] amt);
        return {abs_mode, sem, amt};
    endfunction

endpackage

// File: rtl/sema_rr_arbiter.sv
// Round-robin arbiter: search begins at ptr_i and wraps; one-hot grant plus index.
module sema_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    always_comb begin
        logic          found;
        logic [IW:0]   j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        j       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = {1'b0, ptr_i} + (IW+1)'(i);
            if (j >= (IW+1)'(NREQ)) begin
                j = j - (IW+1)'(NREQ);
            end
            if (!found && req_i[j[IW-1:0]]) begin
                found            = 1'b1;
                valid_o          = 1'b1;
                gnt_o[j[IW-1:0]] = 1'b1;
                idx_o            = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sema_arbiter.sv
// Serialises TAKE/GIVE/PEEK/SET from NREQ requesters onto the semaphore slave bus.
// Define SEMA_ARB_TIMEOUT_EN to make a TAKE give up (ok_o=0) after MAX_RETRY failed attempts.
module sema_arbiter
    import sema_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   req_i,
    input  logic [2*NREQ-1:0] op_i,
    input  logic [8*NREQ-1:0] sem_i,
    input  logic [4*NREQ-1:0] amt_i,
    input  logic [8*NREQ-1:0] wdat_i,
    output logic [NREQ-1:0]   done_o,
    output logic              ok_o,
    output logic [7:0]        rdat_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [12:0]       m_adr_o,
    output logic [7:0]        m_dat_o,
    input  logic              m_ack_i,
    input  logic [7:0]        m_dat_i
);

    localparam int unsigned IW   = $clog2(NREQ);
    localparam logic [7:0]  RMAX = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    op_t         op_q, op_d;
    logic [7:0]  sem_q, sem_d;
    logic [3:0]  amt_q, amt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ok_q, ok_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [12:0] adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  retry_q [NREQ];
    logic [7:0]  retry_d [NREQ];

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_vld;
    op_t             sel_op;
    logic [7:0]      sel_sem;
    logic [3:0]      sel_amt;
    logic [7:0]      sel_wdat;

    sema_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_vld)
    );

    assign sel_op   = op_t'(op_i[2*arb_idx +: 2]);
    assign sel_sem  = sem_i[8*arb_idx +: 8];
    assign sel_amt  = amt_i[4*arb_idx +: 4];
    assign sel_wdat = wdat_i[8*arb_idx +: 8];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        sem_d   = sem_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        retry_d = retry_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_vld && (arb_gnt != '0)) begin
                    idx_d = arb_idx;
                    ptr_d = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
                    op_d  = sel_op;
                    sem_d = sel_sem;
                    amt_d = sel_amt;
                    cnt_d = '0;
                    ok_d  = 1'b1;
                    stb_d = 1'b1;
                    dat_d = '0;
                    unique case (sel_op)
                        OP_TAKE: begin
                            state_d = S_PEEK;
                            we_d    = 1'b0;
                            adr_d   = mk_adr(1'b1, sel_sem, 4'd0);
                        end
                        OP_GIVE: begin
                            state_d = S_ACC;
                            we_d    = 1'b1;
                            adr_d   = mk_adr(1'b0, sel_sem, sel_amt);
                        end
                        OP_PEEK: begin
                            state_d = S_ACC;
                            we_d    = 1'b0;
                            adr_d   = mk_adr(1'b1, sel_sem, 4'd0);
                        end
                        OP_SET: begin
                            state_d = S_ACC;
                            we_d    = 1'b1;
                            adr_d   = mk_adr(1'b1, sel_sem, 4'd0);
                            dat_d   = sel_wdat;
                        end
                    endcase
                end
            end
            S_ACC: begin
                if (m_ack_i) begin
                    state_d = S_RESP;
                    cnt_d   = (op_q == OP_PEEK) ? m_dat_i : '0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                end
            end
            S_PEEK: begin
                if (m_ack_i) begin
                    state_d = S_PGAP;
                    cnt_d   = m_dat_i;
                    stb_d   = 1'b0;
                    adr_d   = '0;
                end
            end
            S_PGAP: begin
                // Strobe is low this cycle, giving the edge-triggered slave its gap before DEC.
                if (cnt_q >= {4'd0, amt_q}) begin
                    if (amt_q == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DEC;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = mk_adr(1'b0, sem_q, amt_q);
                    end
                end else begin
                    state_d = S_IDLE;
                    if (retry_q[idx_q] != RMAX) begin
                        retry_d[idx_q] = retry_q[idx_q] + 8'd1;
                    end
`ifdef SEMA_ARB_TIMEOUT_EN
                    if (retry_q[idx_q] == RMAX) begin
                        state_d = S_RESP;
                        ok_d    = 1'b0;
                    end
`endif
                end
            end
            S_DEC: begin
                if (m_ack_i) begin
                    state_d = S_RESP;
                    stb_d   = 1'b0;
                    adr_d   = '0;
                end
            end
            S_RESP: begin
                state_d        = S_IDLE;
                retry_d[idx_q] = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_TAKE;
            sem_q   <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            retry_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            sem_q   <= sem_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        done_o = '0;
        if (state_q == S_RESP) begin
            done_o[idx_q] = 1'b1;
        end
    end

    assign ok_o    = (state_q == S_RESP) && ok_q;
    assign rdat_o  = (state_q == S_RESP) ? cnt_q : '0;
    assign m_cyc_o = stb_q;
    assign m_stb_o = stb_q;
    assign m_we_o  = we_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;

endmodule

// File: tb/tb_sema_arbiter.sv
// Directed bench for sema_arbiter with a 256x8 saturating semaphore slave (ack one cycle after strobe).
`timescale 1ns/1ps
module tb_sema_arbiter;
    import sema_arb_pkg::*;

    localparam int unsigned NREQ = 4;
`ifdef SEMA_ARB_TIMEOUT_EN
    localparam int unsigned TB_MAX_RETRY = 3;
`else
    localparam int unsigned TB_MAX_RETRY = 255;
`endif

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] op = '0;
    logic [8*NREQ-1:0] sem = '0;
    logic [4*NREQ-1:0] amt = '0;
    logic [8*NREQ-1:0] wdat = '0;
    logic [NREQ-1:0]   done_o;
    logic              ok_o;
    logic [7:0]        rdat_o;
    logic              m_cyc_o, m_stb_o, m_we_o;
    logic [12:0]       m_adr_o;
    logic [7:0]        m_dat_o;
    logic              m_ack = 1'b0;
    logic [7:0]        m_rdat = '0;

    logic [7:0]  mem [256] = '{default: 8'h00};
    int unsigned acc_cnt = 0;
    int          vectors = 0;
    int          errors = 0;
    int unsigned done_q [$];

    logic [7:0]  res_rdat [NREQ];
    logic        res_ok   [NREQ];
    int unsigned res_cyc  [NREQ];
    logic        res_to   [NREQ];

    always #5 clk = ~clk;

    sema_arbiter #(.NREQ(NREQ), .MAX_RETRY(TB_MAX_RETRY)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req),
        .op_i    (op),
        .sem_i   (sem),
        .amt_i   (amt),
        .wdat_i  (wdat),
        .done_o  (done_o),
        .ok_o    (ok_o),
        .rdat_o  (rdat_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack),
        .m_dat_i (m_rdat)
    );

    always @(posedge clk) begin : slave
        logic [7:0] s;
        logic [3:0] a;
        logic [8:0] sum;
        s = m_adr_o[11:4];
        a = m_adr_o[3:0];
        sum = {1'b0, mem[s]} + {5'd0, a};
        if (!rst_ni) begin
            m_ack <= 1'b0;
        end else if (m_stb_o && !m_ack) begin
            m_ack   <= 1'b1;
            acc_cnt <= acc_cnt + 1;
            m_rdat  <= mem[s];
            if (m_adr_o[12]) begin
                if (m_we_o) mem[s] <= m_dat_o;
            end else if (m_we_o) begin
                mem[s] <= sum[8] ? 8'hFF : sum[7:0];
            end else begin
                mem[s] <= (mem[s] >= {4'd0, a}) ? mem[s] - {4'd0, a} : 8'h00;
            end
        end else begin
            m_ack <= 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (done_o[i]) done_q.push_back(i);
        end
    end

    task automatic issue(input int unsigned n, input op_t o, input logic [7:0] s,
                         input logic [3:0] a, input logic [7:0] w, input int unsigned budget);
        int unsigned c = 0;
        logic seen = 1'b0;
        op[2*n +: 2]   = o;
        sem[8*n +: 8]  = s;
        amt[4*n +: 4]  = a;
        wdat[8*n +: 8] = w;
        req[n]    = 1'b1;
        res_to[n] = 1'b1;
        while (!seen && c < budget) begin
            @(negedge clk);
            c++;
            if (done_o[n]) begin
                seen        = 1'b1;
                res_rdat[n] = rdat_o;
                res_ok[n]   = ok_o;
                res_cyc[n]  = c;
                res_to[n]   = 1'b0;
            end
        end
        req[n] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o} !== 24'd0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o});
        end
        vectors++;
        if ({done_o, ok_o, rdat_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_resp: got %h expected 0", {done_o, ok_o, rdat_o});
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({m_stb_o, done_o} !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", {m_stb_o, done_o});
        end
    endtask

    task automatic test_set_take_peek();
        int unsigned a0;
        issue(0, OP_SET, 8'd5, 4'd0, 8'd3, 50);
        vectors++;
        if (res_to[0] !== 1'b0 || res_cyc[0] !== 3 || res_rdat[0] !== 8'd0 || res_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL set: to=%0d cyc=%0d rdat=%0d ok=%0d expected to=0 cyc=3 rdat=0 ok=1",
                     res_to[0], res_cyc[0], res_rdat[0], res_ok[0]);
        end
        vectors++;
        if (mem[5] !== 8'd3) begin errors++; $display("FAIL set_mem: got %0d expected 3", mem[5]); end
        a0 = acc_cnt;
        issue(0, OP_TAKE, 8'd5, 4'd2, 8'd0, 50);
        vectors++;
        if (res_cyc[0] !== 6) begin errors++; $display("FAIL take_latency: got %0d expected 6", res_cyc[0]); end
        vectors++;
        if (res_rdat[0] !== 8'd3 || res_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL take_resp: rdat=%0d ok=%0d expected rdat=3 ok=1", res_rdat[0], res_ok[0]);
        end
        vectors++;
        if (mem[5] !== 8'd1 || acc_cnt - a0 !== 2) begin
            errors++;
            $display("FAIL take_mem: mem=%0d acc=%0d expected mem=1 acc=2", mem[5], acc_cnt - a0);
        end
        issue(0, OP_PEEK, 8'd5, 4'd0, 8'd0, 50);
        vectors++;
        if (res_rdat[0] !== 8'd1 || res_cyc[0] !== 3) begin
            errors++;
            $display("FAIL peek: rdat=%0d cyc=%0d expected rdat=1 cyc=3", res_rdat[0], res_cyc[0]);
        end
    endtask

    task automatic test_take_retry();
        fork
            issue(0, OP_TAKE, 8'd5, 4'd2, 8'd0, 200);
            begin
                repeat (2) @(negedge clk);
                issue(1, OP_GIVE, 8'd5, 4'd4, 8'd0, 200);
            end
        join
        vectors++;
        if (res_to[0] !== 1'b0 || res_rdat[0] !== 8'd5 || res_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL retry_take: to=%0d rdat=%0d ok=%0d expected to=0 rdat=5 ok=1",
                     res_to[0], res_rdat[0], res_ok[0]);
        end
        vectors++;
        if (res_to[1] !== 1'b0 || res_rdat[1] !== 8'd0 || res_cyc[1] !== 5) begin
            errors++;
            $display("FAIL retry_give: to=%0d rdat=%0d cyc=%0d expected to=0 rdat=0 cyc=5",
                     res_to[1], res_rdat[1], res_cyc[1]);
        end
        vectors++;
        if (res_cyc[0] !== 14) begin errors++; $display("FAIL retry_latency: got %0d expected 14", res_cyc[0]); end
        vectors++;
        if (mem[5] !== 8'd3) begin errors++; $display("FAIL retry_mem: got %0d expected 3", mem[5]); end
    endtask

    task automatic rr_round(input int unsigned first);
        int unsigned exp_o [4];
        for (int i = 0; i < 4; i++) exp_o[i] = (first + i) % 4;
        done_q.delete();
        fork
            issue(0, OP_PEEK, 8'd10, 4'd0, 8'd0, 100);
            issue(1, OP_PEEK, 8'd11, 4'd0, 8'd0, 100);
            issue(2, OP_PEEK, 8'd12, 4'd0, 8'd0, 100);
            issue(3, OP_PEEK, 8'd13, 4'd0, 8'd0, 100);
        join
        vectors++;
        if (done_q.size() !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d done pulses expected 4", done_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (done_q[i] !== exp_o[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got req%0d expected req%0d", i, done_q[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        issue(3, OP_PEEK, 8'd0, 4'd0, 8'd0, 50);
        rr_round(0);
        issue(0, OP_PEEK, 8'd0, 4'd0, 8'd0, 50);
        rr_round(1);
    endtask

    task automatic test_timeout();
`ifdef SEMA_ARB_TIMEOUT_EN
        int unsigned a0;
        issue(0, OP_SET, 8'd7, 4'd0, 8'd0, 50);
        for (int k = 0; k < 2; k++) begin
            a0 = acc_cnt;
            issue(0, OP_TAKE, 8'd7, 4'd1, 8'd0, 200);
            vectors++;
            if (res_to[0] !== 1'b0 || res_ok[0] !== 1'b0 || res_rdat[0] !== 8'd0) begin
                errors++;
                $display("FAIL timeout_resp[%0d]: to=%0d ok=%0d rdat=%0d expected to=0 ok=0 rdat=0",
                         k, res_to[0], res_ok[0], res_rdat[0]);
            end
            vectors++;
            if (acc_cnt - a0 !== 4 || res_cyc[0] !== 16) begin
                errors++;
                $display("FAIL timeout_attempts[%0d]: acc=%0d cyc=%0d expected acc=4 cyc=16",
                         k, acc_cnt - a0, res_cyc[0]);
            end
            vectors++;
            if (mem[7] !== 8'd0) begin errors++; $display("FAIL timeout_mem: got %0d expected 0", mem[7]); end
        end
`else
        issue(0, OP_SET, 8'd7, 4'd0, 8'd0, 50);
        fork
            issue(0, OP_TAKE, 8'd7, 4'd1, 8'd0, 300);
            begin
                repeat (40) @(negedge clk);
                vectors++;
                if (res_to[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL spin_no_done: done seen=%0d expected 0", !res_to[0]);
                end
                issue(1, OP_GIVE, 8'd7, 4'd1, 8'd0, 100);
            end
        join
        vectors++;
        if (res_to[0] !== 1'b0 || res_ok[0] !== 1'b1 || res_rdat[0] !== 8'd1) begin
            errors++;
            $display("FAIL spin_take: to=%0d ok=%0d rdat=%0d expected to=0 ok=1 rdat=1",
                     res_to[0], res_ok[0], res_rdat[0]);
        end
        vectors++;
        if (mem[7] !== 8'd0) begin errors++; $display("FAIL spin_mem: got %0d expected 0", mem[7]); end
`endif
    endtask

    task automatic test_saturate();
        int unsigned a0;
        issue(1, OP_SET, 8'd9, 4'd0, 8'hF8, 50);
        issue(1, OP_GIVE, 8'd9, 4'd15, 8'd0, 50);
        vectors++;
        if (mem[9] !== 8'hFF || res_rdat[1] !== 8'd0) begin
            errors++;
            $display("FAIL give_sat1: mem=%h rdat=%h expected mem=ff rdat=00", mem[9], res_rdat[1]);
        end
        issue(1, OP_GIVE, 8'd9, 4'd15, 8'd0, 50);
        vectors++;
        if (mem[9] !== 8'hFF) begin errors++; $display("FAIL give_sat2: got %h expected ff", mem[9]); end
        a0 = acc_cnt;
        issue(1, OP_TAKE, 8'd9, 4'd0, 8'd0, 50);
        vectors++;
        if (res_ok[1] !== 1'b1 || res_rdat[1] !== 8'hFF || res_cyc[1] !== 4) begin
            errors++;
            $display("FAIL take0: ok=%0d rdat=%h cyc=%0d expected ok=1 rdat=ff cyc=4",
                     res_ok[1], res_rdat[1], res_cyc[1]);
        end
        vectors++;
        if (acc_cnt - a0 !== 1 || mem[9] !== 8'hFF) begin
            errors++;
            $display("FAIL take0_nodec: acc=%0d mem=%h expected acc=1 mem=ff", acc_cnt - a0, mem[9]);
        end
    endtask

    task automatic test_reset_midop();
        logic pulsed = 1'b0;
        op[4 +: 2]  = OP_PEEK;
        sem[16 +: 8] = 8'd9;
        req[2] = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_stb_o !== 1'b1) begin errors++; $display("FAIL midop_stb_up: got %0d expected 1", m_stb_o); end
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({m_stb_o, m_cyc_o} !== 2'b00) begin
            errors++;
            $display("FAIL midop_stb_drop: got %b expected 00", {m_stb_o, m_cyc_o});
        end
        req[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== '0) pulsed = 1'b1;
        end
        rst_ni = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done_o !== '0 || m_stb_o !== 1'b0) pulsed = 1'b1;
        end
        vectors++;
        if (pulsed !== 1'b0) begin errors++; $display("FAIL midop_no_done: got activity=%0d expected 0", pulsed); end
        issue(2, OP_PEEK, 8'd9, 4'd0, 8'd0, 50);
        vectors++;
        if (res_to[2] !== 1'b0 || res_rdat[2] !== 8'hFF || res_cyc[2] !== 3) begin
            errors++;
            $display("FAIL post_reset_peek: to=%0d rdat=%h cyc=%0d expected to=0 rdat=ff cyc=3",
                     res_to[2], res_rdat[2], res_cyc[2]);
        end
    endtask

    initial begin
        test_reset();
        test_set_take_peek();
        test_take_retry();
        test_round_robin();
        test_timeout();
        test_saturate();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
